// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory controller.
// Holds the FSM state encoding, the RISC-V funct3 width codes and the size/alignment checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Access size in bytes; 0 marks an encoding that is undefined for this direction.
    function automatic logic [3:0] access_bytes(input logic load, input logic [2:0] funct3);
        logic [3:0] bytes;
        case (funct3)
            F3_LB:   bytes = 4'd1;
            F3_LH:   bytes = 4'd2;
            F3_LW:   bytes = 4'd4;
            F3_LD:   bytes = 4'd8;
            F3_LBU:  bytes = load ? 4'd1 : 4'd0;
            F3_LHU:  bytes = load ? 4'd2 : 4'd0;
            F3_LWU:  bytes = load ? 4'd4 : 4'd0;
            default: bytes = 4'd0;
        endcase
        return bytes;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] bytes, input logic [2:0] addr_lo);
        logic mis;
        case (bytes)
            4'd2:    mis = addr_lo[0];
            4'd4:    mis = |addr_lo[1:0];
            4'd8:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Load data aligner: picks the addressed bytes out of a full memory word
// and sign- or zero-extends them according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int N    = 64,
    parameter int OFFW = 3
) (
    input  logic [N-1:0]    rdata,
    input  logic [OFFW-1:0] offset,
    input  logic [2:0]      funct3,
    output logic [N-1:0]    data
);

    logic [N-1:0] shifted_s;

    // Right-justify the addressed lane, then extend from the access size (funct3[2] = unsigned).
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        data      = shifted_s;
        case (funct3[1:0])
            2'b00: begin
                if (funct3[2]) data = N'(shifted_s[7:0]);
                else           data = N'($signed(shifted_s[7:0]));
            end
            2'b01: begin
                if (funct3[2]) data = N'(shifted_s[15:0]);
                else           data = N'($signed(shifted_s[15:0]));
            end
            2'b10: begin
                if (funct3[2]) data = N'(shifted_s[31:0]);
                else           data = N'($signed(shifted_s[31:0]));
            end
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencing controller between the memory stage and a req/gnt/rvalid data memory.
// Optional access-fault timeout is built when LSU_TIMEOUT_EN is defined.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int N              = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_load,
    input  logic           req_store,
    input  logic [2:0]     req_funct3,
    input  logic [N-1:0]   req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           mem_req,
    input  logic           mem_gnt,
    output logic           mem_we,
    output logic [N-1:0]   mem_addr,
    output logic [N-1:0]   mem_wdata,
    output logic [N/8-1:0] mem_wmask,
    input  logic           mem_rvalid,
    input  logic [N-1:0]   mem_rdata,
    output logic           rsp_valid,
    output logic [N-1:0]   rsp_data,
    output logic           exc_valid,
    output logic           exc_store,
    output logic           exc_fault,
    output logic [N-1:0]   exc_addr,
    output logic           busy
);

    localparam int NB   = N / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e      state_r;
    logic            store_r;
    logic            bad_r;
    logic [2:0]      funct3_r;
    logic            mem_req_r;
    logic            mem_we_r;
    logic [N-1:0]    mem_addr_r;
    logic [N-1:0]    mem_wdata_r;
    logic [NB-1:0]   mem_wmask_r;
    logic            rsp_valid_r;
    logic [N-1:0]    rsp_data_r;
    logic            exc_valid_r;
    logic            exc_store_r;
    logic [N-1:0]    exc_addr_r;
    logic            busy_r;

    logic [3:0]      bytes_s;
    logic            bad_s;
    logic [OFFW-1:0] off_s;
    logic [NB-1:0]   base_mask_s;
    logic [NB-1:0]   mask_s;
    logic [N-1:0]    wdata_s;
    logic [N-1:0]    load_data_s;
    logic            tmo_hit_s;

    // Classify and pre-shape the incoming request so the accept edge can capture bus values.
    always_comb begin
        bytes_s     = access_bytes(req_load, req_funct3);
        off_s       = req_addr[OFFW-1:0];
        bad_s       = (req_load == req_store) || (bytes_s == 4'd0) ||
                      (bytes_s > 4'(NB)) || is_misaligned(bytes_s, req_addr[2:0]);
        base_mask_s = NB'((16'd1 << bytes_s) - 16'd1);
        mask_s      = base_mask_s << off_s;
        wdata_s     = req_wdata << {off_s, 3'b000};
    end

    lsu_load_align #(
        .N    (N),
        .OFFW (OFFW)
    ) u_load_align (
        .rdata  (mem_rdata),
        .offset (mem_addr_r[OFFW-1:0]),
        .funct3 (funct3_r),
        .data   (load_data_s)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt_r;
    logic          exc_fault_r;
    logic          tmo_fire_s;

    // The timeout only fires when the event the state is waiting for did not arrive this cycle.
    always_comb begin
        tmo_hit_s  = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
        tmo_fire_s = tmo_hit_s &&
                     (((state_r == ST_ISSUE) && !bad_r && !mem_gnt) ||
                      ((state_r == ST_WAIT) && !mem_rvalid));
    end

    // Outstanding-access cycle counter; IDLE clears it so it starts at zero on ISSUE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r   <= '0;
            exc_fault_r <= 1'b0;
        end else begin
            exc_fault_r <= tmo_fire_s;
            if (state_r == ST_IDLE) begin
                tmo_cnt_r <= '0;
            end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end
    end

    assign exc_fault = exc_fault_r;
`else
    assign tmo_hit_s = 1'b0;
    assign exc_fault = 1'b0;
`endif

    // Main sequencer; all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            store_r     <= 1'b0;
            bad_r       <= 1'b0;
            funct3_r    <= 3'b000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wmask_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            exc_valid_r <= 1'b0;
            exc_store_r <= 1'b0;
            exc_addr_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            exc_valid_r <= 1'b0;
            exc_store_r <= 1'b0;
            exc_addr_r  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        store_r     <= req_store;
                        bad_r       <= bad_s;
                        funct3_r    <= req_funct3;
                        mem_addr_r  <= req_addr;
                        mem_req_r   <= !bad_s;
                        mem_we_r    <= !bad_s && req_store;
                        mem_wmask_r <= (!bad_s && req_store) ? mask_s : '0;
                        mem_wdata_r <= (!bad_s && req_store) ? wdata_s : '0;
                        rsp_data_r  <= '0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                // Illegal requests spend their check cycle here with mem_req held low.
                ST_ISSUE: begin
                    if (bad_r) begin
                        rsp_valid_r <= 1'b1;
                        exc_valid_r <= 1'b1;
                        exc_store_r <= store_r;
                        exc_addr_r  <= mem_addr_r;
                        state_r     <= ST_RESP;
                    end else if (mem_gnt) begin
                        mem_req_r   <= 1'b0;
                        rsp_valid_r <= store_r;
                        state_r     <= store_r ? ST_RESP : ST_WAIT;
                    end else if (tmo_hit_s) begin
                        mem_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        exc_valid_r <= 1'b1;
                        exc_store_r <= store_r;
                        exc_addr_r  <= mem_addr_r;
                        state_r     <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_data_r  <= load_data_s;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end else if (tmo_hit_s) begin
                        rsp_valid_r <= 1'b1;
                        exc_valid_r <= 1'b1;
                        exc_store_r <= store_r;
                        exc_addr_r  <= mem_addr_r;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == ST_IDLE) && !rst;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wmask = mem_wmask_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign exc_valid = exc_valid_r;
    assign exc_store = exc_store_r;
    assign exc_addr  = exc_addr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (N=64, TIMEOUT_CYCLES=8).
// Covers the timeout path when LSU_TIMEOUT_EN is defined, the unbounded wait otherwise.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        exc_valid;
    logic        exc_store;
    logic        exc_fault;
    logic [63:0] exc_addr;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_mem_ctrl #(
        .N              (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .exc_valid  (exc_valid),
        .exc_store  (exc_store),
        .exc_fault  (exc_fault),
        .exc_addr   (exc_addr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accept edge; returns one step after the accept edge.
    task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd);
        chk("ready_before_accept", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = 64'd0; req_wdata = 64'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        step();
        step();
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_mem_req",   {63'd0, mem_req},   64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_ready_low", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        step();

        // LW 0x1004, grant in ISSUE, rvalid next cycle
        send(1'b1, 1'b0, F3_LW, 64'h1004, 64'd0);
        chk("lw_mem_req",  {63'd0, mem_req},  64'd1);
        chk("lw_mem_we",   {63'd0, mem_we},   64'd0);
        chk("lw_wmask",    {56'd0, mem_wmask}, 64'h00);
        chk("lw_addr",     mem_addr,          64'h1004);
        chk("lw_busy",     {63'd0, busy},     64'd1);
        chk("lw_ready",    {63'd0, req_ready}, 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("lw_req_drop", {63'd0, mem_req},   64'd0);
        chk("lw_no_rsp2",  {63'd0, rsp_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h8000_0001_0000_0000;
        step();
        mem_rvalid = 1'b0;
        chk("lw_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lw_rsp_data",  rsp_data,           64'hFFFF_FFFF_8000_0001);
        chk("lw_exc",       {63'd0, exc_valid}, 64'd0);
        step();
        chk("lw_pulse_end", {63'd0, rsp_valid}, 64'd0);
        chk("lw_idle_busy", {63'd0, busy},      64'd0);

        // SB 0x2003, grant delayed four cycles
        send(1'b0, 1'b1, F3_SB, 64'h2003, 64'h0000_0000_0000_00AB);
        chk("sb_we",    {63'd0, mem_we},    64'd1);
        chk("sb_wmask", {56'd0, mem_wmask}, 64'h08);
        chk("sb_wdata", mem_wdata,          64'h0000_0000_AB00_0000);
        for (int i = 0; i < 4; i++) begin
            chk("sb_req_held", {63'd0, mem_req},   64'd1);
            chk("sb_no_rsp",   {63'd0, rsp_valid}, 64'd0);
            step();
        end
        chk("sb_req_5th",    {63'd0, mem_req},   64'd1);
        chk("sb_wmask_hold", {56'd0, mem_wmask}, 64'h08);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("sb_req_drop",  {63'd0, mem_req},   64'd0);
        chk("sb_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("sb_rsp_data",  rsp_data,           64'd0);
        chk("sb_exc",       {63'd0, exc_valid}, 64'd0);
        step();
        chk("sb_pulse_end", {63'd0, rsp_valid}, 64'd0);

        // SW misaligned at 0x3002
        send(1'b0, 1'b1, F3_SW, 64'h3002, 64'h1234);
        chk("sw_no_req",  {63'd0, mem_req},   64'd0);
        chk("sw_no_rsp1", {63'd0, rsp_valid}, 64'd0);
        step();
        chk("sw_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("sw_exc_valid", {63'd0, exc_valid}, 64'd1);
        chk("sw_exc_store", {63'd0, exc_store}, 64'd1);
        chk("sw_exc_fault", {63'd0, exc_fault}, 64'd0);
        chk("sw_exc_addr",  exc_addr,           64'h3002);
        chk("sw_rsp_data",  rsp_data,           64'd0);
        step();

        // LHU 0x10, one idle WAIT cycle before rvalid
        send(1'b1, 1'b0, F3_LHU, 64'h10, 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        chk("lhu_wait_no_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("lhu_wait_busy",   {63'd0, busy},      64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1234_5678_9ABC_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("lhu_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lhu_rsp_data",  rsp_data,           64'h0000_0000_0000_F00D);
        step();

        // LHU again, reset while in WAIT, then a stale rvalid
        send(1'b1, 1'b0, F3_LHU, 64'h10, 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst = 1'b1;
        step();
        chk("rstw_busy",      {63'd0, busy},      64'd0);
        chk("rstw_mem_req",   {63'd0, mem_req},   64'd0);
        chk("rstw_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        chk("rstw_stale_drop", {63'd0, rsp_valid}, 64'd0);
        chk("rstw_ready",      {63'd0, req_ready}, 64'd1);

        // LB at byte 5, rvalid during ISSUE must be ignored, then sign-extend 0x80
        send(1'b1, 1'b0, F3_LB, 64'h5, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0000_0000_0000_0000;
        step();
        mem_rvalid = 1'b0;
        chk("lb_issue_hold",  {63'd0, mem_req},   64'd1);
        chk("lb_issue_norsp", {63'd0, rsp_valid}, 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0000_8000_0000_0000;
        step();
        mem_rvalid = 1'b0;
        chk("lb_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("lb_rsp_data",  rsp_data,           64'hFFFF_FFFF_FFFF_FF80);
        step();

        // SD full-width store, immediate grant
        send(1'b0, 1'b1, F3_SD, 64'h40, 64'h1122_3344_5566_7788);
        chk("sd_wmask", {56'd0, mem_wmask}, 64'hFF);
        chk("sd_wdata", mem_wdata,          64'h1122_3344_5566_7788);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("sd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        step();

        // Neither load nor store set
        send(1'b0, 1'b0, F3_LW, 64'h8, 64'd0);
        step();
        chk("none_exc_valid", {63'd0, exc_valid}, 64'd1);
        chk("none_exc_store", {63'd0, exc_store}, 64'd0);
        chk("none_exc_addr",  exc_addr,           64'h8);
        step();

        // Undefined load funct3 111
        send(1'b1, 1'b0, 3'b111, 64'h20, 64'd0);
        chk("f3bad_no_req", {63'd0, mem_req}, 64'd0);
        step();
        chk("f3bad_exc_valid", {63'd0, exc_valid}, 64'd1);
        chk("f3bad_exc_store", {63'd0, exc_store}, 64'd0);
        step();

        // Both load and store set
        send(1'b1, 1'b1, F3_LW, 64'h30, 64'd0);
        step();
        chk("both_exc_valid", {63'd0, exc_valid}, 64'd1);
        chk("both_exc_store", {63'd0, exc_store}, 64'd1);
        step();

        // LD never granted
        send(1'b1, 1'b0, F3_LD, 64'h100, 64'd0);
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            chk("tmo_pending", {63'd0, rsp_valid}, 64'd0);
            step();
        end
        chk("tmo_still_req", {63'd0, mem_req}, 64'd1);
        step();
        chk("tmo_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("tmo_exc_valid", {63'd0, exc_valid}, 64'd1);
        chk("tmo_exc_fault", {63'd0, exc_fault}, 64'd1);
        chk("tmo_exc_store", {63'd0, exc_store}, 64'd0);
        chk("tmo_exc_addr",  exc_addr,           64'h100);
        chk("tmo_req_drop",  {63'd0, mem_req},   64'd0);
        step();
`else
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid !== 1'b0) begin
                chk("notmo_no_rsp", {63'd0, rsp_valid}, 64'd0);
            end
            step();
        end
        chk("notmo_busy",    {63'd0, busy},    64'd1);
        chk("notmo_mem_req", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif
        chk("final_idle", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Sequencing controller between the pipeline's memory stage and a single-port data memory with a req/gnt/rvalid handshake. It accepts one load/store request at a time and checks size and alignment. It issues the access with the byte mask and shifted write data, then waits for the grant and the read response. It returns sign- or zero-extended load data, or a misalignment/fault exception, as a one-cycle response pulse.

Parameters:
N, 64, data/address width (power of two, 32 or 64)
TIMEOUT_CYCLES, 64, cycles in ISSUE+WAIT before an access fault (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  pipeline request valid
req_ready  out  1  high only in IDLE and while rst low; transfer when req_valid && req_ready
req_load  in  1  load request
req_store  in  1  store request
req_funct3  in  3  RISC-V width/sign encoding
req_addr  in  N  effective byte address
req_wdata  in  N  store data, right-justified
mem_req  out  1  memory request, held until mem_gnt
mem_gnt  in  1  memory accepted the request
mem_we  out  1  1 = write
mem_addr  out  N  byte address (captured req_addr)
mem_wdata  out  N  store data shifted by byte_offset*8
mem_wmask  out  N/8  byte enables; 0 for loads
mem_rvalid  in  1  read data valid
mem_rdata  in  N  full aligned memory word
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  N  extended load data; 0 for stores and exceptions
exc_valid  out  1  qualifies rsp_valid: exception response
exc_store  out  1  1 = store/AMO cause, 0 = load cause
exc_fault  out  1  1 = access fault (timeout), 0 = misaligned
exc_addr  out  N  faulting address
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset puts the FSM in IDLE. All registered outputs reset to 0, so rsp_valid, mem_req and busy are 0 in the cycle after reset.
- IDLE: on transfer, capture load, store, funct3, addr and wdata.
  - Check the captured request. Any of the following goes to RESP with exc_valid=1 and exc_fault=0:
    - load && store both set (exc_store=1)
    - neither load nor store set (exc_store=0)
    - undefined funct3 (load 111; store 1xx)
    - access size > N/8
    - misaligned address: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0
  - Otherwise go to ISSUE.
- ISSUE: mem_req=1; mem_addr, mem_we, mem_wmask and mem_wdata are stable until the grant.
  - mem_wmask = ((1<<bytes)-1) << addr[log2(N/8)-1:0].
  - On mem_gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid is ignored in ISSUE.
- WAIT: mem_req=0. On mem_rvalid, shift mem_rdata right by offset*8, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) from the access size. Latch the result into rsp_data and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready stays 0 in RESP, so requests cannot be back-to-back into the same cycle.
- Latency from the accept edge, with gnt and rvalid arriving at the earliest legal cycle:
  - load: rsp_valid 3 cycles after accept
  - store: rsp_valid 2 cycles after accept
  - exception: rsp_valid 2 cycles after accept
- mem_rvalid is earliest the cycle after mem_gnt. mem_rvalid seen in IDLE or RESP (for example a stale response after reset) is dropped.
- rst in any state: the FSM goes to IDLE next edge, mem_req drops, and no response is produced. The memory is responsible for discarding the outstanding access.
- Requests presented while busy are not accepted, because req_ready=0.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT_CYCLES-1 without the completing event, the FSM goes to RESP with exc_valid=1, exc_fault=1, exc_store=store and exc_addr=addr. A gnt or rvalid arriving in the same cycle as the timeout wins.
- Undefined: no counter, exc_fault is tied to 0, and the FSM can wait indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - the FSM state enum
  - funct3 constants (LB..LD, LBU..LWU, SB..SD)
  - function access_bytes(load, funct3) returning 0 for invalid encodings
  - function is_misaligned(bytes, addr)
- One sub-module, lsu_load_align (combinational: rdata, offset, funct3 -> extended data), instantiated in WAIT.

Test Plan:
- LW: addr 0x1004, gnt in the ISSUE cycle, rvalid next cycle with rdata 0x8000_0001_0000_0000 -> rsp_data 0xFFFF_FFFF_8000_0001, rsp_valid exactly 3 cycles after accept.
- SB: addr 0x2003, wdata 0xAB, gnt delayed 4 cycles -> mem_req held for 5 cycles, mem_wmask 0x08, mem_wdata 0xAB00_0000, then one rsp_valid with rsp_data 0.
- SW: addr 0x3002 -> no mem_req; exc_valid=1, exc_store=1, exc_fault=0, exc_addr 0x3002, 2 cycles after accept.
- LHU: addr 0x10, rvalid in WAIT with rdata byte lanes [1:0]=0xF00D -> rsp_data 0x0000_F00D. Second case: assert rst in WAIT, then deliver rvalid -> no rsp_valid, and req_ready=1 the cycle after rst deasserts.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, an LD never granted -> exc_valid=1, exc_fault=1, 8 cycles after ISSUE entry. Without the macro -> still busy after 100 cycles.
